// File: rtl/cache_pkg.sv
// Shared types, default geometry and field-width helper for the set-associative cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITE_MEM,
    REFILL,
    RESPOND
  } state_t;

  localparam int DEF_WIDTH       = 64;
  localparam int DEF_ADDRESSSIZE = 64;
  localparam int DEF_BLOCKSZ     = 512;
  localparam int DEF_NUMSETS     = 256;
  localparam int DEF_NUMWAYS     = 2;

  // Width of a field selecting one of n items; never collapses to zero bits.
  function automatic int field_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: per-set tag, valid bit and line storage.
// Writes land on the clock edge; the selected set is read combinationally.
module cache_way
  import cache_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int BLOCKSZ = DEF_BLOCKSZ,
  parameter int NUMSETS = DEF_NUMSETS,
  parameter int TAG_W   = 50,
  parameter int IDX_W   = field_w(DEF_NUMSETS),
  parameter int WSEL_W  = field_w(DEF_BLOCKSZ / DEF_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [IDX_W-1:0]   index,
  input  logic               fill_en,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCKSZ-1:0] fill_line,
  input  logic               word_en,
  input  logic [WSEL_W-1:0]  word_sel,
  input  logic [WIDTH-1:0]   word_data,
  output logic [TAG_W-1:0]   tag,
  output logic               valid,
  output logic [BLOCKSZ-1:0] line
);

  logic [TAG_W-1:0]   tag_mem  [NUMSETS];
  logic [BLOCKSZ-1:0] data_mem [NUMSETS];
  logic [NUMSETS-1:0] valid_bits;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid_bits <= '0;
    end else if (fill_en) begin
      valid_bits[index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; only the valid bits make them meaningful.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_en) begin
        tag_mem[index]  <= fill_tag;
        data_mem[index] <= fill_line;
      end else if (word_en) begin
        data_mem[index][word_sel*WIDTH +: WIDTH] <= word_data;
      end
    end
  end

  assign tag   = tag_mem[index];
  assign valid = valid_bits[index];
  assign line  = data_mem[index];

endmodule

// File: rtl/cache_assoc.sv
// Set-associative, write-through, no-write-allocate cache with round-robin
// replacement and a single outstanding request at a time.
module cache_assoc
  import cache_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ADDRESSSIZE = DEF_ADDRESSSIZE,
  parameter int BLOCKSZ     = DEF_BLOCKSZ,
  parameter int NUMSETS     = DEF_NUMSETS,
  parameter int NUMWAYS     = DEF_NUMWAYS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   wr_en,
  input  logic [ADDRESSSIZE-1:0] r_addr,
  input  logic [ADDRESSSIZE-1:0] w_addr,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   operation_complete,
  input  logic                   invalidate,
  output logic                   mem_req,
  output logic [ADDRESSSIZE-1:0] mem_address,
  output logic [WIDTH-1:0]       mem_data_out,
  output logic                   mem_wr_en,
  input  logic [BLOCKSZ-1:0]     mem_data_in,
  input  logic                   mem_data_valid
);

  localparam int WORDS  = BLOCKSZ / WIDTH;
  localparam int OFF_W  = field_w(BLOCKSZ / 8);
  localparam int BYTE_W = field_w(WIDTH / 8);
  localparam int IDX_W  = field_w(NUMSETS);
  localparam int WSEL_W = field_w(WORDS);
  localparam int WAY_W  = field_w(NUMWAYS);
  localparam int TAG_W  = ADDRESSSIZE - OFF_W - IDX_W;

  state_t state;

  logic                   req_wr;
  logic [ADDRESSSIZE-1:0] req_addr;
  logic [WIDTH-1:0]       req_data;
  logic                   wr_hit;
  logic [WAY_W-1:0]       wr_way;
  logic [WAY_W-1:0]       rr_ptr [NUMSETS];

  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_index;
  logic [WSEL_W-1:0]  word_sel;

  logic [TAG_W-1:0]   way_tag   [NUMWAYS];
  logic [BLOCKSZ-1:0] way_line  [NUMWAYS];
  logic [NUMWAYS-1:0] way_valid;
  logic [NUMWAYS-1:0] match;
  logic [NUMWAYS-1:0] fill_en;
  logic [NUMWAYS-1:0] word_en;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [WIDTH-1:0]   hit_word;
  logic [WAY_W-1:0]   victim;
  logic [WAY_W-1:0]   rr_cur;
  logic [WAY_W-1:0]   rr_next;
  logic               inval_all;

  // The request is latched at acceptance so every later stage sees one address.
  assign req_tag   = req_addr[ADDRESSSIZE-1 -: TAG_W];
  assign req_index = req_addr[OFF_W +: IDX_W];
  assign word_sel  = (WORDS > 1) ? req_addr[BYTE_W +: WSEL_W] : '0;
  assign inval_all = (state == IDLE) && invalidate;

  for (genvar w = 0; w < NUMWAYS; w++) begin : g_way
    cache_way #(
      .WIDTH   (WIDTH),
      .BLOCKSZ (BLOCKSZ),
      .NUMSETS (NUMSETS),
      .TAG_W   (TAG_W),
      .IDX_W   (IDX_W),
      .WSEL_W  (WSEL_W)
    ) u_way (
      .clk       (clk),
      .rst       (rst),
      .clear     (inval_all),
      .index     (req_index),
      .fill_en   (fill_en[w]),
      .fill_tag  (req_tag),
      .fill_line (mem_data_in),
      .word_en   (word_en[w]),
      .word_sel  (word_sel),
      .word_data (req_data),
      .tag       (way_tag[w]),
      .valid     (way_valid[w]),
      .line      (way_line[w])
    );
  end

  always_comb begin
    match    = '0;
    hit_way  = '0;
    hit_word = '0;
    for (int w = 0; w < NUMWAYS; w++) begin
      match[w] = way_valid[w] && (way_tag[w] == req_tag);
      if (match[w]) begin
        hit_way  = WAY_W'(w);
        hit_word = way_line[w][word_sel*WIDTH +: WIDTH];
      end
    end
    hit = $onehot(match);
  end

  // Lowest-numbered empty way wins; otherwise the set's round-robin pointer.
  always_comb begin
    rr_cur  = rr_ptr[req_index];
    rr_next = (rr_cur == WAY_W'(NUMWAYS - 1)) ? '0 : rr_cur + 1'b1;
    victim  = rr_cur;
    for (int w = NUMWAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim = WAY_W'(w);
    end
  end

  // Array updates happen only on the memory handshake so a reset abandons them cleanly.
  always_comb begin
    fill_en = '0;
    word_en = '0;
    for (int w = 0; w < NUMWAYS; w++) begin
      fill_en[w] = !rst && (state == REFILL) && mem_data_valid && (victim == WAY_W'(w));
      word_en[w] = !rst && (state == WRITE_MEM) && mem_data_valid && wr_hit
                   && (wr_way == WAY_W'(w));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      data_out           <= '0;
      operation_complete <= 1'b0;
      mem_req            <= 1'b0;
      mem_wr_en          <= 1'b0;
      mem_address        <= '0;
      mem_data_out       <= '0;
      req_wr             <= 1'b0;
      req_addr           <= '0;
      req_data           <= '0;
      wr_hit             <= 1'b0;
      wr_way             <= '0;
      for (int s = 0; s < NUMSETS; s++) rr_ptr[s] <= '0;
    end else begin
      operation_complete <= 1'b0;
      case (state)
        IDLE: begin
          if (invalidate) begin
            for (int s = 0; s < NUMSETS; s++) rr_ptr[s] <= '0;
          end else if (enable) begin
            req_wr   <= wr_en;
            req_addr <= wr_en ? w_addr : r_addr;
            req_data <= data_in;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (req_wr) begin
            wr_hit       <= hit;
            wr_way       <= hit_way;
            mem_wr_en    <= 1'b1;
            mem_address  <= req_addr;
            mem_data_out <= req_data;
            state        <= WRITE_MEM;
          end else if (hit) begin
            data_out           <= hit_word;
            operation_complete <= 1'b1;
            state              <= RESPOND;
          end else begin
            mem_req     <= 1'b1;
            mem_address <= {req_addr[ADDRESSSIZE-1:OFF_W], {OFF_W{1'b0}}};
            state       <= REFILL;
          end
        end
        REFILL: begin
          if (mem_data_valid) begin
            mem_req            <= 1'b0;
            rr_ptr[req_index]  <= rr_next;
            data_out           <= mem_data_in[word_sel*WIDTH +: WIDTH];
            operation_complete <= 1'b1;
            state              <= RESPOND;
          end
        end
        WRITE_MEM: begin
          if (mem_data_valid) begin
            mem_wr_en          <= 1'b0;
            operation_complete <= 1'b1;
            state              <= RESPOND;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_assoc.sv
// Directed checks of cache_assoc: refill, hits, replacement, write-through,
// reset abandonment and invalidate, at the default 2-way geometry.
module tb_cache_assoc;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         wr_en;
  logic [63:0]  r_addr;
  logic [63:0]  w_addr;
  logic [63:0]  data_in;
  logic [63:0]  data_out;
  logic         operation_complete;
  logic         invalidate;
  logic         mem_req;
  logic [63:0]  mem_address;
  logic [63:0]  mem_data_out;
  logic         mem_wr_en;
  logic [511:0] mem_data_in;
  logic         mem_data_valid;

  int tests    = 0;
  int failures = 0;

  cache_assoc dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .wr_en              (wr_en),
    .r_addr             (r_addr),
    .w_addr             (w_addr),
    .data_in            (data_in),
    .data_out           (data_out),
    .operation_complete (operation_complete),
    .invalidate         (invalidate),
    .mem_req            (mem_req),
    .mem_address        (mem_address),
    .mem_data_out       (mem_data_out),
    .mem_wr_en          (mem_wr_en),
    .mem_data_in        (mem_data_in),
    .mem_data_valid     (mem_data_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [511:0] mkBlock(input logic [63:0] base);
    logic [511:0] b;
    for (int i = 0; i < 8; i++) b[i*64 +: 64] = base + 64'(i);
    return b;
  endfunction

  // Present one request for a single acceptance edge, then drop enable.
  task automatic applyStimulus(input logic wr, input logic [63:0] addr,
                               input logic [63:0] data);
    enable  = 1'b1;
    wr_en   = wr;
    r_addr  = wr ? 64'h0 : addr;
    w_addr  = wr ? addr : 64'h0;
    data_in = data;
    tick();
    enable = 1'b0;
  endtask

  task automatic doRead(input string name, input logic [63:0] addr, input bit hit,
                        input logic [63:0] maddr, input logic [511:0] blk,
                        input logic [63:0] exp);
    applyStimulus(1'b0, addr, 64'h0);
    tick();
    if (hit) begin
      checkOutput({name, " done"}, operation_complete, 1);
      checkOutput({name, " no mem_req"}, mem_req, 0);
      checkOutput({name, " data"}, data_out, exp);
    end else begin
      checkOutput({name, " mem_req"}, mem_req, 1);
      checkOutput({name, " mem_address"}, mem_address, maddr);
      checkOutput({name, " not done"}, operation_complete, 0);
      tick();
      checkOutput({name, " mem_req held"}, mem_req, 1);
      mem_data_in    = blk;
      mem_data_valid = 1'b1;
      tick();
      mem_data_valid = 1'b0;
      checkOutput({name, " done"}, operation_complete, 1);
      checkOutput({name, " mem_req drop"}, mem_req, 0);
      checkOutput({name, " data"}, data_out, exp);
    end
    tick();
    checkOutput({name, " pulse end"}, operation_complete, 0);
  endtask

  task automatic doWrite(input string name, input logic [63:0] addr,
                         input logic [63:0] data, input logic [63:0] held);
    applyStimulus(1'b1, addr, data);
    tick();
    checkOutput({name, " mem_wr_en"}, mem_wr_en, 1);
    checkOutput({name, " mem_address"}, mem_address, addr);
    checkOutput({name, " mem_data_out"}, mem_data_out, data);
    checkOutput({name, " no mem_req"}, mem_req, 0);
    tick();
    checkOutput({name, " wr held"}, mem_wr_en, 1);
    checkOutput({name, " not done"}, operation_complete, 0);
    mem_data_valid = 1'b1;
    tick();
    mem_data_valid = 1'b0;
    checkOutput({name, " done"}, operation_complete, 1);
    checkOutput({name, " wr drop"}, mem_wr_en, 0);
    checkOutput({name, " data_out kept"}, data_out, held);
    tick();
    checkOutput({name, " pulse end"}, operation_complete, 0);
  endtask

  initial begin
    rst            = 1'b1;
    enable         = 1'b0;
    wr_en          = 1'b0;
    r_addr         = '0;
    w_addr         = '0;
    data_in        = '0;
    invalidate     = 1'b0;
    mem_data_in    = '0;
    mem_data_valid = 1'b0;
    tick();
    tick();
    checkOutput("reset data_out", data_out, 0);
    checkOutput("reset complete", operation_complete, 0);
    checkOutput("reset mem_req", mem_req, 0);
    checkOutput("reset mem_wr_en", mem_wr_en, 0);
    checkOutput("reset mem_address", mem_address, 0);
    checkOutput("reset mem_data_out", mem_data_out, 0);
    rst = 1'b0;
    tick();

    doRead("rd1000 miss", 64'h1000, 1'b0, 64'h1000, mkBlock(64'hAAAA_AAAA_AAAA_AAAA),
           64'hAAAA_AAAA_AAAA_AAAA);
    doRead("rd1000 hit", 64'h1000, 1'b1, 64'h0, '0, 64'hAAAA_AAAA_AAAA_AAAA);
    doRead("rd1008 hit", 64'h1008, 1'b1, 64'h0, '0, 64'hAAAA_AAAA_AAAA_AAAB);

    // Set 0: fill both ways, then a third tag evicts way 0.
    doRead("rd0000 miss", 64'h0000, 1'b0, 64'h0000, mkBlock(64'h1111_0000_0000_0000),
           64'h1111_0000_0000_0000);
    doRead("rd4000 miss", 64'h4000, 1'b0, 64'h4000, mkBlock(64'h2222_0000_0000_0000),
           64'h2222_0000_0000_0000);
    doRead("rd0000 hit", 64'h0000, 1'b1, 64'h0, '0, 64'h1111_0000_0000_0000);
    doRead("rd4010 hit", 64'h4010, 1'b1, 64'h0, '0, 64'h2222_0000_0000_0002);
    doRead("rd8000 miss", 64'h8000, 1'b0, 64'h8000, mkBlock(64'h3333_0000_0000_0000),
           64'h3333_0000_0000_0000);
    doRead("rd4000 still hit", 64'h4000, 1'b1, 64'h0, '0, 64'h2222_0000_0000_0000);
    doRead("rd0038 evicted", 64'h0038, 1'b0, 64'h0000, mkBlock(64'h1111_0000_0000_0000),
           64'h1111_0000_0000_0007);
    doRead("rd8000 hit", 64'h8000, 1'b1, 64'h0, '0, 64'h3333_0000_0000_0000);

    doWrite("wr1000 hit", 64'h1000, 64'h1234, 64'h3333_0000_0000_0000);
    doRead("rd1000 updated", 64'h1000, 1'b1, 64'h0, '0, 64'h1234);
    doWrite("wr2000 miss", 64'h2000, 64'h5678, 64'h1234);
    doRead("rd2000 no alloc", 64'h2000, 1'b0, 64'h2000, mkBlock(64'h4444_0000_0000_0000),
           64'h4444_0000_0000_0000);

    // Reset while a refill is outstanding.
    applyStimulus(1'b0, 64'h3000, 64'h0);
    tick();
    checkOutput("rst-refill mem_req", mem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst-refill mem_req cleared", mem_req, 0);
    checkOutput("rst-refill data_out cleared", data_out, 0);
    checkOutput("rst-refill mem_address cleared", mem_address, 0);
    mem_data_in    = mkBlock(64'h6666_0000_0000_0000);
    mem_data_valid = 1'b1;
    tick();
    mem_data_valid = 1'b0;
    checkOutput("late ack no complete", operation_complete, 0);
    checkOutput("late ack no mem_req", mem_req, 0);
    tick();
    checkOutput("late ack still idle", operation_complete, 0);
    doRead("rd3000 after rst", 64'h3000, 1'b0, 64'h3000, mkBlock(64'h6666_0000_0000_0000),
           64'h6666_0000_0000_0000);
    doRead("rd1000 after rst", 64'h1000, 1'b0, 64'h1000, mkBlock(64'h5555_0000_0000_0000),
           64'h5555_0000_0000_0000);
    doRead("rd1000 rehit", 64'h1000, 1'b1, 64'h0, '0, 64'h5555_0000_0000_0000);

    // Invalidate wins over a simultaneous request.
    enable     = 1'b1;
    wr_en      = 1'b0;
    r_addr     = 64'h1000;
    invalidate = 1'b1;
    tick();
    enable     = 1'b0;
    invalidate = 1'b0;
    checkOutput("inval no complete", operation_complete, 0);
    checkOutput("inval no mem_req", mem_req, 0);
    tick();
    checkOutput("inval ignored complete", operation_complete, 0);
    checkOutput("inval ignored mem_req", mem_req, 0);
    tick();
    doRead("rd1000 after inval", 64'h1000, 1'b0, 64'h1000, mkBlock(64'h7777_0000_0000_0000),
           64'h7777_0000_0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
